// File: rtl/demosaic_mask_ctrl.sv
// Sequencer for the Bayer demosaic mask bank: counts window-centre pixels, derives site/border
// sideband and delays it to line up with the mask outputs. Optional statistics: DEMOSAIC_CTRL_STATS_EN.
module demosaic_mask_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int CW       = 12,
    parameter int PIPE_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_start_i,
    input  logic        in_valid_i,
    input  logic [1:0]  bayer_pat_i,
    output logic        mask_clken_o,
    output logic        out_valid_o,
    output logic [1:0]  out_site_o,
    output logic        out_border_o,
    output logic        out_eol_o,
    output logic        out_eof_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        err_pulse_o
`ifdef DEMOSAIC_CTRL_STATS_EN
    ,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] err_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
    localparam logic [CW-1:0] EDGE_LO  = CW'(2);
    localparam logic [CW-1:0] COL_HI   = CW'(IMG_W - 3);
    localparam logic [CW-1:0] ROW_HI   = CW'(IMG_H - 3);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(PIPE_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    pat_q, pat_d;
    logic [FW-1:0] flush_q, flush_d;

    // chain entry: {valid, site[1:0], border, eol, eof}
    logic [5:0]    chain_q [PIPE_LAT];

    logic [CW-1:0] curRow, curCol;
    logic [1:0]    curPat;
    logic          accept;
    logic [1:0]    pixSite;
    logic          pixBorder, pixEol, pixEof;
    logic [5:0]    stageIn;
    logic          flushDone;
    logic          errPulse;

    // A frame_start pixel is coordinate (0,0) under the newly presented pattern.
    always_comb begin
        curRow    = frame_start_i ? '0 : row_q;
        curCol    = frame_start_i ? '0 : col_q;
        curPat    = frame_start_i ? bayer_pat_i : pat_q;
        accept    = in_valid_i & (frame_start_i | (state_q == ST_ACTIVE));
        pixSite   = {curRow[0] ^ curPat[1], curCol[0] ^ curPat[0]};
        pixEol    = (curCol == LAST_COL);
        pixEof    = pixEol & (curRow == LAST_ROW);
        pixBorder = (curRow < EDGE_LO) | (curRow > ROW_HI) | (curCol < EDGE_LO) | (curCol > COL_HI);
        stageIn   = accept ? {1'b1, pixSite, pixBorder, pixEol, pixEof} : 6'd0;
        flushDone = (state_q == ST_FLUSH) & (flush_q == '0) & ~frame_start_i;
        errPulse  = (frame_start_i & (state_q != ST_IDLE))
                  | (in_valid_i & ~frame_start_i & (state_q != ST_ACTIVE));
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pat_d   = pat_q;
        flush_d = flush_q;
        if (frame_start_i) begin
            state_d = ST_ACTIVE;
            row_d   = '0;
            col_d   = '0;
            pat_d   = bayer_pat_i;
        end else if (state_q == ST_FLUSH) begin
            if (flush_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                flush_d = flush_q - FW'(1);
            end
        end
        if (accept) begin
            if (pixEof) begin
                state_d = ST_FLUSH;
                row_d   = '0;
                col_d   = '0;
                flush_d = FLUSH_INIT;
            end else if (pixEol) begin
                col_d = '0;
                row_d = curRow + CW'(1);
            end else begin
                col_d = curCol + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pat_q   <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pat_q   <= pat_d;
            flush_q <= flush_d;
        end
    end

    // Free-running like the mask pipeline, so stalls never skew the alignment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q[0] <= stageIn;
            for (int i = 1; i < PIPE_LAT; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign mask_clken_o = accept;
    assign out_valid_o  = chain_q[PIPE_LAT-1][5];
    assign out_site_o   = chain_q[PIPE_LAT-1][4:3];
    assign out_border_o = chain_q[PIPE_LAT-1][2];
    assign out_eol_o    = chain_q[PIPE_LAT-1][1];
    assign out_eof_o    = chain_q[PIPE_LAT-1][0];
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = flushDone;
    assign err_pulse_o  = errPulse;

`ifdef DEMOSAIC_CTRL_STATS_EN
    logic [15:0] frameCnt_q, errCnt_q;

    // Frame count wraps; error count sticks at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frameCnt_q <= '0;
            errCnt_q   <= '0;
        end else begin
            if (flushDone) begin
                frameCnt_q <= frameCnt_q + 16'd1;
            end
            if (errPulse && (errCnt_q != 16'hFFFF)) begin
                errCnt_q <= errCnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt_o = frameCnt_q;
    assign err_cnt_o   = errCnt_q;
`endif

endmodule

// File: tb/tb_demosaic_mask_ctrl.sv
// Directed bench for demosaic_mask_ctrl (8x6 image, 3-cycle latency) with a scoreboard of
// expected mask outputs keyed by the cycle in which they must appear.
module tb_demosaic_mask_ctrl;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int LAT = 3;

    typedef struct {
        int         due;
        logic [1:0] site;
        logic       border;
        logic       eol;
        logic       eof;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frameStart = 1'b0;
    logic       inValid = 1'b0;
    logic [1:0] bayerPat = 2'd0;

    logic       maskClken, outValid, outBorder, outEol, outEof, busy, frameDone, errPulse;
    logic [1:0] outSite;
`ifdef DEMOSAIC_CTRL_STATS_EN
    logic [15:0] frameCnt, errCnt;
`endif

    int   checks = 0;
    int   passed = 0;
    int   cycle = 0;
    bit   frameOpen = 0;
    int   mRow = 0;
    int   mCol = 0;
    logic [1:0] mPat = 2'd0;
    int   doneCnt = 0;
    int   errCnt_m = 0;
    exp_t sb [$];

    demosaic_mask_ctrl #(.IMG_W(W), .IMG_H(H), .CW(12), .PIPE_LAT(LAT)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .frame_start_i (frameStart),
        .in_valid_i    (inValid),
        .bayer_pat_i   (bayerPat),
        .mask_clken_o  (maskClken),
        .out_valid_o   (outValid),
        .out_site_o    (outSite),
        .out_border_o  (outBorder),
        .out_eol_o     (outEol),
        .out_eof_o     (outEof),
        .busy_o        (busy),
        .frame_done_o  (frameDone),
        .err_pulse_o   (errPulse)
`ifdef DEMOSAIC_CTRL_STATS_EN
        ,
        .frame_cnt_o   (frameCnt),
        .err_cnt_o     (errCnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_out_valid"}, 16'(outValid), 16'd0);
        checkOutput({tag, "_busy"}, 16'(busy), 16'd0);
        checkOutput({tag, "_frame_done"}, 16'(frameDone), 16'd0);
        checkOutput({tag, "_err"}, 16'(errPulse), 16'd0);
        checkOutput({tag, "_clken"}, 16'(maskClken), 16'd0);
        checkOutput({tag, "_side"}, 16'({outSite, outBorder, outEol, outEof}), 16'd0);
    endtask

    // One clock cycle: drive, check at the falling edge, update the model, advance.
    task automatic applyStimulus(input logic fs, input logic iv, input logic [1:0] pat);
        exp_t       rec;
        bit         acc, expErr, eofPending, expBusy;
        logic [1:0] par;
        frameStart = fs;
        inValid    = iv;
        bayerPat   = pat;
        @(negedge clk);
        eofPending = 0;
        foreach (sb[i]) if (sb[i].eof) eofPending = 1;
        expBusy = frameOpen || eofPending;
        acc     = iv && (fs || frameOpen);
        expErr  = (fs && expBusy) || (iv && !fs && !frameOpen);
        checkOutput("mask_clken", 16'(maskClken), 16'(acc));
        checkOutput("err_pulse", 16'(errPulse), 16'(expErr));
        checkOutput("busy", 16'(busy), 16'(expBusy));
        if (sb.size() > 0 && sb[0].due < cycle) begin
            checkOutput("sb_missed", 16'(sb[0].due), 16'(cycle));
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cycle) begin
            rec = sb.pop_front();
            checkOutput("out_valid", 16'(outValid), 16'd1);
            checkOutput("out_site", 16'(outSite), 16'(rec.site));
            checkOutput("out_border", 16'(outBorder), 16'(rec.border));
            checkOutput("out_eol", 16'(outEol), 16'(rec.eol));
            checkOutput("out_eof", 16'(outEof), 16'(rec.eof));
            checkOutput("frame_done", 16'(frameDone), 16'(rec.eof));
            if (rec.eof) doneCnt++;
        end else begin
            checkOutput("idle_out_valid", 16'(outValid), 16'd0);
            checkOutput("idle_sideband", 16'({outSite, outBorder, outEol, outEof}), 16'd0);
            checkOutput("idle_frame_done", 16'(frameDone), 16'd0);
        end
        if (expErr) errCnt_m++;
        if (fs) begin
            frameOpen = 1;
            mRow = 0;
            mCol = 0;
            mPat = pat;
        end
        if (acc) begin
            par        = {mRow[0], mCol[0]};
            rec.due    = cycle + LAT;
            rec.site   = mPat ^ par;
            rec.border = (mRow < 2) || (mRow >= H - 2) || (mCol < 2) || (mCol >= W - 2);
            rec.eol    = (mCol == W - 1);
            rec.eof    = rec.eol && (mRow == H - 1);
            sb.push_back(rec);
            mCol++;
            if (mCol == W) begin
                mCol = 0;
                mRow++;
                if (mRow == H) begin
                    mRow = 0;
                    frameOpen = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    initial begin
        int guard;
        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] frame 1: RGGB back-to-back");
        applyStimulus(1'b1, 1'b0, 2'd0);
        repeat (W * H) applyStimulus(1'b0, 1'b1, 2'd0);
        repeat (LAT + 2) applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("frame1_done_count", 16'(doneCnt), 16'd1);

        $display("[TB] frame 2: GRBG with random gaps");
        applyStimulus(1'b1, 1'b0, 2'd1);
        guard = 0;
        while (frameOpen && guard < 1000) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 2'd0);
            guard++;
        end
        checkOutput("gap_frame_complete", 16'(frameOpen), 16'd0);
        repeat (LAT + 2) applyStimulus(1'b0, 1'b0, 2'd0);

        $display("[TB] frame 3: BGGR, first pixel with frame_start");
        applyStimulus(1'b1, 1'b1, 2'd3);
        repeat (W * H - 1) applyStimulus(1'b0, 1'b1, 2'd0);
        repeat (LAT + 2) applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("frame3_done_count", 16'(doneCnt), 16'd3);

        $display("[TB] abort after 20 pixels, restart GBRG");
        applyStimulus(1'b1, 1'b0, 2'd2);
        repeat (20) applyStimulus(1'b0, 1'b1, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd2);
        repeat (W * H) applyStimulus(1'b0, 1'b1, 2'd0);
        repeat (LAT + 2) applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("abort_done_count", 16'(doneCnt), 16'd4);

        $display("[TB] stray valids in IDLE and FLUSH");
        repeat (3) applyStimulus(1'b0, 1'b1, 2'd0);
        applyStimulus(1'b1, 1'b1, 2'd0);
        repeat (W * H - 1) applyStimulus(1'b0, 1'b1, 2'd0);
        repeat (LAT + 2) applyStimulus(1'b0, 1'b1, 2'd0);
        checkOutput("flush_done_count", 16'(doneCnt), 16'd5);

`ifdef DEMOSAIC_CTRL_STATS_EN
        checkOutput("frame_cnt", frameCnt, 16'(doneCnt));
        checkOutput("err_cnt", errCnt, 16'(errCnt_m));
`endif

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 1'b0, 2'd0);
        repeat (10) applyStimulus(1'b0, 1'b1, 2'd0);
        frameStart = 1'b0;
        inValid    = 1'b0;
        rst_n      = 1'b0;
        #1;
        checkAllZero("midreset");
`ifdef DEMOSAIC_CTRL_STATS_EN
        checkOutput("midreset_frame_cnt", frameCnt, 16'd0);
        checkOutput("midreset_err_cnt", errCnt, 16'd0);
`endif
        sb.delete();
        frameOpen = 0;
        mRow = 0;
        mCol = 0;
        doneCnt = 0;
        errCnt_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b0, 2'd1);
        repeat (W * H) applyStimulus(1'b0, 1'b1, 2'd0);
        repeat (LAT + 3) applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("post_reset_done_count", 16'(doneCnt), 16'd1);
        checkOutput("sb_empty", 16'(sb.size()), 16'd0);
`ifdef DEMOSAIC_CTRL_STATS_EN
        checkOutput("final_frame_cnt", frameCnt, 16'(doneCnt));
        checkOutput("final_err_cnt", errCnt, 16'(errCnt_m));
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
